// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
//   Wishbone classic (B3) initiator. Accepts read/write commands on a
//   valid/ready port and runs them on the WB bus as single beats or
//   incrementing bursts. Read beats return data on a response port.
//   A stall watchdog aborts a beat that is never acknowledged.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only while IDLE, so command
//   inputs are not sampled while busy. rsp_valid is a one-cycle pulse with
//   no backpressure.
//
// Ports
//   wb_clk_i, wb_rst_i             clock, async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_we/adr/dat/sel/len         command fields (len = beats-1)
//   wbm_cyc_o/stb_o/we_o/sel_o     WB control outputs
//   wbm_adr_o/dat_o                WB address / write data
//   wbm_dat_i/ack_i                WB read data / acknowledge
//   rsp_valid/dat/last/err         response pulse
//   busy                           high in any state other than IDLE
// -----------------------------------------------------------------------------
module wb_host_master #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             rsp_valid,
    output logic [31:0]      rsp_dat,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_last_q, rsp_last_d;
    logic               rsp_err_q, rsp_err_d;

    // Byte-lane bits of the command address are forced to zero on latch.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^cmd_adr[1:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        // Response fields are single-cycle pulses; zero unless set below.
        rsp_valid_d = 1'b0;
        rsp_dat_d   = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    adr_d   = {cmd_adr[31:2], 2'b00};
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    we_d    = cmd_we;
                    cnt_d   = cmd_len;
                    wdog_d  = '0;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (wbm_ack_i) begin
                    wdog_d = '0;
                    if (!we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = wbm_dat_i;
                    end
                    if (cnt_q != '0) begin
                        adr_d   = adr_q + 32'd4;   // natural 32-bit wrap
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = GAP;
                    end else begin
                        // Writes report once, on the final beat, with zero data.
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (wdog_q == WD_LAST) begin
                    // Ack on this same cycle would have won; no ack, so abort.
                    wdog_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            GAP: begin
                // One idle strobe cycle so an ack-once responder sees a new beat.
                state_d = BEAT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus controls decode straight from state so reset releases them at once.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wbm_cyc_o = (state_q != IDLE);
    assign wbm_stb_o = (state_q == BEAT);
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic [3:0]  cmd_len = '0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        rsp_valid, rsp_last, rsp_err, busy;
    logic [31:0] rsp_dat;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses {dat, last, err} and bus beats {we, adr, dat, sel, more}.
    logic [33:0] exp_q[$];
    logic [69:0] beat_q[$];

    logic slave_ack_en = 1'b1;
    logic prev_more    = 1'b0;

    wb_host_master #(.LEN_W(4), .TIMEOUT(16)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .cmd_len  (cmd_len),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .rsp_valid(rsp_valid),
        .rsp_dat  (rsp_dat),
        .rsp_last (rsp_last),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- slave model ----------------
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign wbm_dat_i = rd_model(wbm_adr_o);

    // Acks one cycle after strobe rises, for exactly one cycle.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wbm_ack_i <= 1'b0;
        else          wbm_ack_i <= slave_ack_en & wbm_cyc_o & wbm_stb_o & ~wbm_ack_i;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- response monitor ----------------
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("rsp_dat",  rsp_dat, e[33:2]);
                check("rsp_last", {31'd0, rsp_last}, {31'd0, e[1]});
                check("rsp_err",  {31'd0, rsp_err},  {31'd0, e[0]});
                if (rsp_last) check("ready_at_last", {31'd0, cmd_ready}, 32'd1);
            end
        end
    end

    // ---------------- bus monitor ----------------
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (prev_more) begin
                check("gap_cyc", {31'd0, wbm_cyc_o}, 32'd1);
                check("gap_stb", {31'd0, wbm_stb_o}, 32'd0);
                prev_more = 1'b0;
            end
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [69:0] b;
                    b = beat_q.pop_front();
                    check("beat_we",  {31'd0, wbm_we_o}, {31'd0, b[69]});
                    check("beat_adr", wbm_adr_o, b[68:37]);
                    if (b[69]) check("beat_dat", wbm_dat_o, b[36:5]);
                    check("beat_sel", {28'd0, wbm_sel_o}, {28'd0, b[4:1]});
                    prev_more = b[0];
                end
            end
        end else begin
            prev_more = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] len);
        logic [31:0] a;
        a = {adr[31:2], 2'b00};
        for (int i = 0; i <= int'(len); i++) begin
            beat_q.push_back({we, a, dat, sel, (i != int'(len))});
            if (!we) exp_q.push_back({rd_model(a), (i == int'(len)), 1'b0});
            a = a + 32'd4;
        end
        if (we) exp_q.push_back({32'd0, 1'b1, 1'b0});
    endtask

    // Offers a command and returns at the negedge following the accept edge.
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [3:0] len,
                            input logic b2b, input logic keep);
        int w;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_len   = len;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge wb_clk_i);
            w++;
        end
        if (w >= 100) check("accept_timeout", 32'd0, 32'd1);
        else if (b2b) check("b2b_accept_on_last", {31'd0, rsp_last}, 32'd1);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0) && w < 200) begin
            @(negedge wb_clk_i);
            w++;
        end
        if (w >= 200) check(name, 32'd0, 32'd1);
        @(negedge wb_clk_i);
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        int run;
        int w;
        repeat (2) @(negedge wb_clk_i);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_cyc",       {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_stb",       {31'd0, wbm_stb_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_adr",       wbm_adr_o,          32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // 1: single read
        push_expect(1'b0, 32'h3000_0000, 32'd0, 4'hF, 4'd0);
        send_cmd(1'b0, 32'h3000_0000, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0);
        check("t1_stb_after_accept", {31'd0, wbm_stb_o}, 32'd1);
        check("t1_ready_low",        {31'd0, cmd_ready}, 32'd0);
        wait_idle("t1_idle_timeout");

        // 2: write fill burst of 4 (low address bits ignored)
        push_expect(1'b1, 32'h3000_0010, 32'hA5A5_A5A5, 4'hF, 4'd3);
        send_cmd(1'b1, 32'h3000_0013, 32'hA5A5_A5A5, 4'hF, 4'd3, 1'b0, 1'b0);
        wait_idle("t2_idle_timeout");

        // 3: read never acknowledged -> watchdog abort
        slave_ack_en = 1'b0;
        exp_q.push_back({32'd0, 1'b1, 1'b1});
        send_cmd(1'b0, 32'h3000_0040, 32'd0, 4'h3, 4'd0, 1'b0, 1'b0);
        run = 0;
        while (wbm_stb_o && run < 40) begin
            run++;
            @(negedge wb_clk_i);
        end
        check("t3_stb_cycles", run,                  32'd16);
        check("t3_cyc_low",    {31'd0, wbm_cyc_o},   32'd0);
        check("t3_ready",      {31'd0, cmd_ready},   32'd1);
        check("t3_err_pulse",  {31'd0, rsp_err},     32'd1);
        slave_ack_en = 1'b1;
        wait_idle("t3_idle_timeout");

        // 4: burst read wrapping past the top of the address space
        push_expect(1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF, 4'd1);
        send_cmd(1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF, 4'd1, 1'b0, 1'b0);
        wait_idle("t4_idle_timeout");

        // 5: reset during beat 2 of a 4-beat write; only beat 1 completes
        beat_q.push_back({1'b1, 32'h3000_0100, 32'h1234_5678, 4'hC, 1'b1});
        send_cmd(1'b1, 32'h3000_0100, 32'h1234_5678, 4'hC, 4'd3, 1'b0, 1'b0);
        w = 0;
        while (wbm_stb_o && w < 20) begin @(negedge wb_clk_i); w++; end
        while (!wbm_stb_o && w < 20) begin @(negedge wb_clk_i); w++; end
        check("t5_reached_beat2", {31'd0, wbm_stb_o}, 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("t5_cyc",       {31'd0, wbm_cyc_o}, 32'd0);
        check("t5_stb",       {31'd0, wbm_stb_o}, 32'd0);
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_ready",     {31'd0, cmd_ready}, 32'd1);
        check("t5_busy",      {31'd0, busy},      32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // 6: back-to-back commands with cmd_valid held high
        push_expect(1'b0, 32'h3000_0200, 32'd0,        4'hF, 4'd0);
        push_expect(1'b1, 32'h3000_0300, 32'hCAFE_0001, 4'h5, 4'd1);
        push_expect(1'b0, 32'h3000_0400, 32'd0,        4'hA, 4'd2);
        send_cmd(1'b0, 32'h3000_0200, 32'd0,         4'hF, 4'd0, 1'b0, 1'b1);
        send_cmd(1'b1, 32'h3000_0300, 32'hCAFE_0001, 4'h5, 4'd1, 1'b1, 1'b1);
        send_cmd(1'b0, 32'h3000_0400, 32'd0,         4'hA, 4'd2, 1'b1, 1'b0);
        wait_idle("t6_idle_timeout");

        check("rsp_queue_empty",  exp_q.size(),  32'd0);
        check("beat_queue_empty", beat_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
